spi_eeprom_slave: RTL and testbench

SPI_EEPROM_SLAVE -- requirements
Module: spi_eeprom_slave

---
 rtl/spi_eeprom_pkg.sv | 25 ++
 rtl/spi_in_sync.sv | 31 +++
 rtl/spi_eeprom_slave.sv | 167 ++++++++++++++++
 tb/tb_spi_eeprom_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, FSM state type and status-byte helper for the SPI EEPROM slave.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RDSR,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin with single-clk edge strobes.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 EEPROM-style slave (WREN/WRDI/RDSR/READ/WRITE) fronting a byte RAM.
module spi_eeprom_slave
  import spi_eeprom_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_csn,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        a_wen,
  output logic [15:0] a_addr,
  output logic [7:0]  a_din,
  input  logic [7:0]  a_dout,
  output logic        wel
);

  localparam int SW = $clog2(SYNC_STAGES + 2);

  logic csn_q, csn_rise_raw, csn_fall_raw;
  logic sck_q, sck_rise_raw, sck_fall_raw;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_ok;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_csn), .q(csn_q), .rise(csn_rise_raw), .fall(csn_fall_raw)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_q), .rise(sck_rise_raw), .fall(sck_fall_raw)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_ok = &{1'b0, sck_q, mosi_rise, mosi_fall};

  // Edges are masked until the synchronisers have flushed their reset values,
  // so a reset released inside a CSN-low frame lands in IGNORE, not CMD.
  logic [SW-1:0] settle_cnt;
  logic          settled;

  assign settled = (settle_cnt == SW'(SYNC_STAGES + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        settle_cnt <= '0;
    else if (!settled) settle_cnt <= settle_cnt + SW'(1);
  end

  logic csn_rise, csn_fall, sck_rise, sck_fall;
  assign csn_rise = settled & csn_rise_raw;
  assign csn_fall = settled & csn_fall_raw;
  assign sck_rise = settled & sck_rise_raw;
  assign sck_fall = settled & sck_fall_raw;

  state_t      state;
  logic [6:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [7:0]  txsh;
  logic        is_read;
  logic        wr_inc;
  logic [1:0]  rd_stage;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        tx_active;

  assign rx_byte   = {shreg, mosi_q};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
  assign tx_active = (state == ST_RD_DATA) || (state == ST_RDSR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      txsh        <= '0;
      a_addr      <= '0;
      a_din       <= '0;
      a_wen       <= 1'b0;
      wel         <= 1'b0;
      is_read     <= 1'b0;
      wr_inc      <= 1'b0;
      rd_stage    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      a_wen       <= 1'b0;
      wr_inc      <= 1'b0;
      spi_miso_oe <= tx_active;

      if (wr_inc) a_addr <= a_addr + 16'd1;

      if (!tx_active) begin
        spi_miso <= 1'b0;
      end else if (sck_fall) begin
        spi_miso <= txsh[7];
        txsh     <= {txsh[6:0], 1'b0};
      end

      // Prefetch: address held for one clk, RAM data taken on the next.
      case (rd_stage)
        2'd1: rd_stage <= 2'd2;
        2'd2: begin
          txsh     <= a_dout;
          a_addr   <= a_addr + 16'd1;
          rd_stage <= 2'd0;
        end
        default: ;
      endcase

      if (sck_rise && state != ST_IDLE) begin
        shreg   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            is_read <= (rx_byte == OP_READ);
            case (rx_byte)
              OP_WREN: begin wel <= 1'b1; state <= ST_IGNORE; end
              OP_WRDI: begin wel <= 1'b0; state <= ST_IGNORE; end
              OP_RDSR: begin txsh <= status_byte(wel); state <= ST_RDSR; end
              OP_READ, OP_WRITE: state <= ST_ADDR_HI;
              default: state <= ST_IGNORE;
            endcase
          end
          ST_ADDR_HI: begin
            a_addr[15:8] <= rx_byte;
            state        <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            a_addr[7:0] <= rx_byte;
            if (is_read) begin
              rd_stage <= 2'd1;
              state    <= ST_RD_DATA;
            end else begin
              state <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: rd_stage <= 2'd1;
          ST_WR_DATA: begin
            a_wen  <= wel;
            a_din  <= rx_byte;
            wr_inc <= 1'b1;
          end
          ST_RDSR: txsh <= status_byte(wel);
          default: ;
        endcase
      end

      if (state == ST_IDLE && settled && !csn_q)
        state <= csn_fall ? ST_CMD : ST_IGNORE;

      // Placed last so a frame end wins over any byte-driven transition above.
      if (csn_rise) begin
        state   <= ST_IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
        if (state == ST_WR_DATA) wel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed plus randomized SPI transactions checked against a byte-level EEPROM model.
module tb_spi_eeprom_slave;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_csn, spi_sck, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        a_wen;
  logic [15:0] a_addr;
  logic [7:0]  a_din;
  logic [7:0]  a_dout;
  logic        wel;

  int checks = 0;
  int errors = 0;

  spi_eeprom_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .a_wen(a_wen), .a_addr(a_addr),
    .a_din(a_din), .a_dout(a_dout), .wel(wel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h96;
  endfunction

  // Byte RAM attached to the DUT; stores the difference from init_val.
  bit [7:0] ram_x [0:65535];
  always @(posedge clk) begin
    a_dout <= ram_x[a_addr] ^ init_val(a_addr);
    if (a_wen) ram_x[a_addr] <= a_din ^ init_val(a_addr);
  end

  logic [15:0] wl_addr [$];
  logic [7:0]  wl_data [$];
  always @(posedge clk) begin
    if (a_wen) begin
      wl_addr.push_back(a_addr);
      wl_data.push_back(a_din);
    end
  end

  // Reference model state
  logic [7:0] ref_mem [int];
  logic       ref_wel = 1'b0;
  int         wl_rd = 0;
  int         miso_bad = 0;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  logic [7:0] txb [16];
  logic [7:0] rxb [16];
  logic       oeb [16];
  logic [7:0] wdat [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_seen);
    rx = '0;
    oe_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      oe_seen = spi_miso_oe;
      if (!spi_miso_oe && spi_miso) miso_bad++;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) spi_bits(txb[i], 8, rxb[i], oeb[i]);
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic chk_no_writes(input string tag);
    chk(tag, wl_addr.size() - wl_rd, 0);
    wl_rd = wl_addr.size();
  endtask

  task automatic op_cmd(input logic [7:0] op);
    txb[0] = op;
    frame(1);
    if (op == 8'h06) ref_wel = 1'b1;
    if (op == 8'h04) ref_wel = 1'b0;
    chk("wel_after_cmd", wel, ref_wel);
  endtask

  task automatic op_write(input logic [15:0] addr, input int n);
    int exp_n;
    logic [15:0] a;
    txb[0] = 8'h02; txb[1] = addr[15:8]; txb[2] = addr[7:0];
    for (int i = 0; i < n; i++) txb[3+i] = wdat[i];
    frame(3 + n);
    exp_n = ref_wel ? n : 0;
    chk("wr_pulse_count", wl_addr.size() - wl_rd, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      a = 16'(addr + 16'(i));
      ref_mem[int'(a)] = wdat[i];
      if (wl_rd + i < wl_addr.size()) begin
        chk("wr_addr", wl_addr[wl_rd+i], a);
        chk("wr_data", wl_data[wl_rd+i], wdat[i]);
      end
    end
    wl_rd = wl_addr.size();
    if (n > 0) ref_wel = 1'b0;
    chk("wel_after_write", wel, ref_wel);
  endtask

  task automatic op_read(input logic [15:0] addr, input int n);
    txb[0] = 8'h03; txb[1] = addr[15:8]; txb[2] = addr[7:0];
    for (int i = 0; i < n; i++) txb[3+i] = 8'($urandom);
    frame(3 + n);
    for (int i = 0; i < n; i++) chk("rd_data", rxb[3+i], ref_rd(16'(addr + 16'(i))));
    chk("rd_oe", oeb[3], 1'b1);
    chk_no_writes("rd_no_write");
  endtask

  task automatic op_rdsr(input int n);
    txb[0] = 8'h05;
    for (int i = 0; i < n; i++) txb[1+i] = 8'h00;
    frame(1 + n);
    for (int i = 0; i < n; i++) chk("rdsr", rxb[1+i], {6'b0, ref_wel, 1'b0});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_wen"}, a_wen, 1'b0);
    chk({tag, "_a_addr"}, a_addr, 16'h0000);
    chk({tag, "_a_din"}, a_din, 8'h00);
    chk({tag, "_miso"}, spi_miso, 1'b0);
    chk({tag, "_oe"}, spi_miso_oe, 1'b0);
    chk({tag, "_wel"}, wel, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic        oe;
    logic [15:0] addr;
    int          n;

    rst_n = 1'b0; spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // WREN + WRITE 0x1234 A5,5A
    op_cmd(8'h06);
    wdat[0] = 8'hA5; wdat[1] = 8'h5A;
    op_write(16'h1234, 2);

    // READ 0x1234 x3
    op_read(16'h1234, 3);

    // Write with wel=0 is dropped
    wdat[0] = 8'h77;
    op_write(16'h0010, 1);
    op_read(16'h0010, 1);

    // Address wrap
    op_cmd(8'h06);
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    op_write(16'hFFFF, 2);
    op_read(16'hFFFF, 2);

    // Status register
    op_cmd(8'h06);
    op_rdsr(2);
    op_cmd(8'h04);
    op_rdsr(1);

    // Unknown opcode
    txb[0] = 8'h9F; txb[1] = 8'hFF; txb[2] = 8'hA5;
    frame(3);
    chk("ign_miso1", rxb[1], 8'h00);
    chk("ign_miso2", rxb[2], 8'h00);
    chk("ign_oe1", oeb[1], 1'b0);
    chk("ign_oe2", oeb[2], 1'b0);
    chk_no_writes("ign_no_write");

    // CSN raised after 4 bits of a data byte
    op_cmd(8'h06);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h02, 8, rx, oe);
    spi_bits(8'h00, 8, rx, oe);
    spi_bits(8'h40, 8, rx, oe);
    spi_bits(8'hC3, 4, rx, oe);
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    ref_wel = 1'b0;
    chk_no_writes("abort_no_write");
    chk("abort_wel", wel, ref_wel);
    op_rdsr(1);
    op_read(16'h0040, 1);

    // Randomized write/readback
    for (int k = 0; k < 8; k++) begin
      addr = (k % 3 == 0) ? 16'(16'hFFFD + 16'($urandom_range(0, 2))) : 16'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) op_cmd(8'h06);
      op_write(addr, n);
      op_read(addr, n + 1);
    end

    // Reset pulsed in the middle of a READ frame
    op_cmd(8'h06);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, rx, oe);
    spi_bits(8'h00, 8, rx, oe);
    spi_bits(8'h10, 8, rx, oe);
    spi_bits(8'h00, 3, rx, oe);
    rst_n = 1'b0;
    ref_wel = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    spi_bits(8'h00, 5, rx, oe);
    spi_bits(8'h00, 8, rx, oe);
    chk("postrst_miso", rx, 8'h00);
    chk("postrst_oe", oe, 1'b0);
    spi_bits(8'h06, 8, rx, oe);
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("postrst_wel", wel, ref_wel);
    chk_no_writes("postrst_no_write");
    op_rdsr(1);
    op_read(16'h0010, 2);

    chk("miso_without_oe", miso_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
